carryless_poly_reducer: RTL and testbench



---
 rtl/carryless_pkg.sv | 18 +
 rtl/poly_reduce_step.sv | 22 ++
 rtl/carryless_poly_reducer.sv | 102 ++++++++++
 tb/tb_carryless_poly_reducer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/carryless_pkg.sv
// Shared types and sizing helpers for the carry-less polynomial reducer.
package carryless_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  // Step-counter width; kept at least one bit so a single-pass configuration still elaborates.
  function automatic int unsigned cnt_width(input int unsigned data_width,
                                            input int unsigned bits_per_cycle);
    int unsigned w;
    w = $clog2(data_width / bits_per_cycle);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/poly_reduce_step.sv
// One MSB-first long-division step over GF(2): shift in one dividend bit and
// subtract (xor) the polynomial when the bit shifted out of rem was set.
module poly_reduce_step
  import carryless_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rem,
  input  logic                  in_bit,
  input  logic [DATA_WIDTH-1:0] poly,
  output logic [DATA_WIDTH-1:0] next_rem
);

  logic fb;

  // The implicit x^N term cancels the bit shifted out, so only poly is xored in.
  always_comb begin
    fb       = rem[DATA_WIDTH-1];
    next_rem = {rem[DATA_WIDTH-2:0], in_bit} ^ (fb ? poly : '0);
  end

endmodule

// File: rtl/carryless_poly_reducer.sv
// Sequential reducer: (H*x^N xor L) mod (x^N + poly), BITS_PER_CYCLE bits per clock.
module carryless_poly_reducer
  import carryless_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [DATA_WIDTH-1:0] product_high_i,
  input  logic [DATA_WIDTH-1:0] product_low_i,
  input  logic [DATA_WIDTH-1:0] poly_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] remainder_o
);

  localparam int unsigned Steps = DATA_WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CntW  = cnt_width(DATA_WIDTH, BITS_PER_CYCLE);
  localparam logic [CntW-1:0] LastCnt = CntW'(Steps - 1);

  if ((DATA_WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_cfg
    $error("BITS_PER_CYCLE must divide DATA_WIDTH");
  end

  state_e                state_q;
  logic [DATA_WIDTH-1:0] rem_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] poly_q;
  logic [DATA_WIDTH-1:0] result_q;
  logic [CntW-1:0]       count_q;
  logic                  ready_q;
  logic                  valid_q;

  // chain[0] is the current remainder; chain[BITS_PER_CYCLE] is this cycle's update.
  logic [BITS_PER_CYCLE:0][DATA_WIDTH-1:0] chain;

  assign chain[0] = rem_q;

  for (genvar j = 0; j < BITS_PER_CYCLE; j++) begin : g_step
    poly_reduce_step #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_step (
      .rem     (chain[j]),
      .in_bit  (shift_q[DATA_WIDTH-1-j]),
      .poly    (poly_q),
      .next_rem(chain[j+1])
    );
  end

  // Control FSM plus datapath registers; all outputs come straight from flops.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q  <= StIdle;
      rem_q    <= '0;
      shift_q  <= '0;
      poly_q   <= '0;
      result_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (valid_i) begin
            rem_q   <= product_high_i;
            shift_q <= product_low_i;
            poly_q  <= poly_i;
            count_q <= '0;
            ready_q <= 1'b0;
            state_q <= StBusy;
          end
        end
        StBusy: begin
          rem_q   <= chain[BITS_PER_CYCLE];
          shift_q <= shift_q << BITS_PER_CYCLE;
          count_q <= count_q + 1'b1;
          if (count_q == LastCnt) begin
            result_q <= chain[BITS_PER_CYCLE];
            valid_q  <= 1'b1;
            state_q  <= StDone;
          end
        end
        StDone: begin
          if (ready_i) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ready_o     = ready_q;
  assign valid_o     = valid_q;
  assign remainder_o = result_q;

endmodule

// File: tb/tb_carryless_poly_reducer.sv
// Self-checking bench: three reducer configurations, scoreboard queues per instance.
module tb_carryless_poly_reducer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [2:0]  vi;
  logic [2:0]  ri;
  wire  [2:0]  vo;
  wire  [2:0]  ro;
  logic [31:0] h [3];
  logic [31:0] l [3];
  logic [31:0] p [3];
  wire  [7:0]  rem0;
  wire  [7:0]  rem1;
  wire  [31:0] rem2;

  int checks   = 0;
  int failures = 0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] q2[$];

  // Instance 0: N=8, k=1.  Instance 1: N=8, k=8.  Instance 2: N=32, k=4.
  carryless_poly_reducer #(.DATA_WIDTH(8), .BITS_PER_CYCLE(1)) u_dut0 (
    .clk_i(clk), .rst_n_i(rst_n), .valid_i(vi[0]), .ready_o(ro[0]),
    .product_high_i(h[0][7:0]), .product_low_i(l[0][7:0]), .poly_i(p[0][7:0]),
    .valid_o(vo[0]), .ready_i(ri[0]), .remainder_o(rem0)
  );
  carryless_poly_reducer #(.DATA_WIDTH(8), .BITS_PER_CYCLE(8)) u_dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .valid_i(vi[1]), .ready_o(ro[1]),
    .product_high_i(h[1][7:0]), .product_low_i(l[1][7:0]), .poly_i(p[1][7:0]),
    .valid_o(vo[1]), .ready_i(ri[1]), .remainder_o(rem1)
  );
  carryless_poly_reducer #(.DATA_WIDTH(32), .BITS_PER_CYCLE(4)) u_dut2 (
    .clk_i(clk), .rst_n_i(rst_n), .valid_i(vi[2]), .ready_o(ro[2]),
    .product_high_i(h[2]), .product_low_i(l[2]), .poly_i(p[2]),
    .valid_o(vo[2]), .ready_i(ri[2]), .remainder_o(rem2)
  );

  function automatic int width_of(input int s);
    return (s == 2) ? 32 : 8;
  endfunction

  function automatic int lat_of(input int s);
    return (s == 1) ? 1 : 8;
  endfunction

  function automatic logic [31:0] get_rem(input int s);
    case (s)
      0:       return {24'b0, rem0};
      1:       return {24'b0, rem1};
      default: return rem2;
    endcase
  endfunction

  function automatic logic [31:0] mask_of(input int n);
    return (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
  endfunction

  // Reference: textbook long division of the 2N-bit dividend by the full N+1-bit polynomial.
  function automatic logic [31:0] ref_mod(input logic [31:0] hh, input logic [31:0] ll,
                                          input logic [31:0] pp, input int n);
    logic [63:0] v;
    logic [63:0] pf;
    v  = ({32'b0, hh & mask_of(n)} << n) | {32'b0, ll & mask_of(n)};
    pf = {32'b0, pp & mask_of(n)} | (64'd1 << n);
    for (int i = 2 * n - 1; i >= n; i--) begin
      if (v[i]) v = v ^ (pf << (i - n));
    end
    return v[31:0] & mask_of(n);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input int s, input logic [31:0] v);
    case (s)
      0:       q0.push_back(v);
      1:       q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endtask

  // Scoreboard: compare on the cycle before each completing handshake edge.
  always @(negedge clk) begin
    logic [31:0] e;
    for (int s = 0; s < 3; s++) begin
      if (rst_n && vo[s] && ri[s]) begin
        int sz;
        sz = (s == 0) ? q0.size() : (s == 1) ? q1.size() : q2.size();
        if (sz == 0) begin
          chk($sformatf("spurious_result%0d", s), {31'b0, vo[s]}, 32'd0);
        end else begin
          case (s)
            0:       e = q0.pop_front();
            1:       e = q1.pop_front();
            default: e = q2.pop_front();
          endcase
          chk($sformatf("result%0d", s), get_rem(s), e);
        end
      end
    end
  end

  // One full transaction with the consumer always ready; checks latency and return to idle.
  task automatic run_op(input int s, input logic [31:0] hh, input logic [31:0] ll,
                        input logic [31:0] pp, input logic [31:0] exp);
    int n;
    @(negedge clk);
    chk($sformatf("ready_before%0d", s), {31'b0, ro[s]}, 32'd1);
    h[s] = hh; l[s] = ll; p[s] = pp;
    vi[s] = 1'b1;
    ri[s] = 1'b1;
    push(s, exp);
    @(posedge clk); #1;
    vi[s] = 1'b0;
    h[s] = $urandom; l[s] = $urandom; p[s] = $urandom;
    n = 0;
    while (!vo[s] && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk($sformatf("latency%0d", s), n, lat_of(s));
    @(posedge clk); #1;
    chk($sformatf("ready_after%0d", s), {31'b0, ro[s]}, 32'd1);
    chk($sformatf("valid_after%0d", s), {31'b0, vo[s]}, 32'd0);
  endtask

  initial begin
    int n;
    int k;
    int nr;
    int rise [2];
    logic prev;
    logic [31:0] hh, ll, pp;

    rst_n = 1'b0;
    vi = '0;
    ri = '0;
    for (int s = 0; s < 3; s++) begin
      h[s] = '0; l[s] = '0; p[s] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("reset_valid%0d", s), {31'b0, vo[s]}, 32'd0);
      chk($sformatf("reset_ready%0d", s), {31'b0, ro[s]}, 32'd1);
      chk($sformatf("reset_rem%0d", s), get_rem(s), 32'd0);
    end

    // Directed N=8 vectors.
    run_op(0, 32'h2B, 32'h79, 32'h1B, 32'hC1);
    run_op(0, 32'h01, 32'h00, 32'h1B, 32'h1B);
    run_op(0, 32'h00, 32'h57, 32'h1B, 32'h57);
    run_op(0, 32'hFF, 32'hA5, 32'h00, 32'hA5);
    run_op(1, 32'h2B, 32'h79, 32'h1B, 32'hC1);
    run_op(1, 32'hFF, 32'hA5, 32'h00, 32'hA5);

    // Backpressure: result held for 10 stalled cycles while inputs churn.
    @(negedge clk);
    h[0] = 32'h2B; l[0] = 32'h79; p[0] = 32'h1B;
    vi[0] = 1'b1;
    ri[0] = 1'b0;
    push(0, 32'hC1);
    @(posedge clk); #1;
    vi[0] = 1'b0;
    n = 0;
    while (!vo[0] && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_latency", n, 8);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vi[0] = ~vi[0];
      h[0] = $urandom; l[0] = $urandom; p[0] = $urandom;
      @(posedge clk); #1;
      chk("bp_valid", {31'b0, vo[0]}, 32'd1);
      chk("bp_rem", get_rem(0), 32'hC1);
      chk("bp_ready", {31'b0, ro[0]}, 32'd0);
    end
    vi[0] = 1'b0;
    ri[0] = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_ready", {31'b0, ro[0]}, 32'd1);
    chk("bp_release_valid", {31'b0, vo[0]}, 32'd0);

    // Back-to-back with valid_i and ready_i tied high.
    @(negedge clk);
    h[0] = 32'h2B; l[0] = 32'h79; p[0] = 32'h1B;
    vi[0] = 1'b1;
    ri[0] = 1'b1;
    push(0, 32'hC1);
    push(0, ref_mod(32'h3C, 32'hD2, 32'h1D, 8));
    @(posedge clk); #1;
    h[0] = 32'h3C; l[0] = 32'hD2; p[0] = 32'h1D;
    rise[0] = -1;
    rise[1] = -1;
    nr = 0;
    k = 0;
    prev = 1'b0;
    while (nr < 2 && k < 60) begin
      @(posedge clk); #1;
      k++;
      if (vo[0] && !prev) begin
        rise[nr] = k;
        nr++;
        if (nr == 2) vi[0] = 1'b0;
      end
      prev = vo[0];
    end
    vi[0] = 1'b0;
    chk("b2b_first_latency", rise[0], 8);
    chk("b2b_spacing", rise[1] - rise[0], 10);
    @(posedge clk); #1;
    chk("b2b_idle_ready", {31'b0, ro[0]}, 32'd1);

    // Reset in the third busy cycle aborts the operation without output.
    @(negedge clk);
    h[0] = 32'h2B; l[0] = 32'h79; p[0] = 32'h1B;
    vi[0] = 1'b1;
    ri[0] = 1'b1;
    @(posedge clk); #1;
    vi[0] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_valid", {31'b0, vo[0]}, 32'd0);
    chk("rst_ready", {31'b0, ro[0]}, 32'd1);
    chk("rst_rem", get_rem(0), 32'd0);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (vo[0]) n++;
    end
    chk("rst_no_spurious", n, 0);
    run_op(0, 32'h2B, 32'h79, 32'h1B, 32'hC1);

    // Random sweeps against the reference model.
    for (int i = 0; i < 12; i++) begin
      hh = $urandom; ll = $urandom; pp = $urandom;
      if (i == 0) pp = 32'h0;
      if (i == 1) pp = 32'h0000_0087;
      run_op(2, hh, ll, pp, ref_mod(hh, ll, pp, width_of(2)));
    end
    for (int i = 0; i < 6; i++) begin
      hh = $urandom_range(255); ll = $urandom_range(255); pp = $urandom_range(255);
      run_op(1, hh, ll, pp, ref_mod(hh, ll, pp, 8));
      run_op(0, hh, ll, pp, ref_mod(hh, ll, pp, 8));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("queue0_empty", q0.size(), 0);
    chk("queue1_empty", q1.size(), 0);
    chk("queue2_empty", q2.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
